rx_ack_nak_gen: RTL and testbench

- Receive-side Data Link Layer sequence checker and ACK/NAK scheduler; the counterpart of the TX replay logic that consumes `dllp_packet`.
- Inspects each received TLP's 12-bit sequence number and LCRC status, forwards in-order good TLPs to the Transaction Layer, and drops all others.
- Produces ACK/NAK DLLPs in `dllp_packet` layout toward the DLLP framer.
- Sits between the RX LCRC checker and the TX DLLP arbiter.

---
 rtl/rx_ack_nak_gen.sv | 154 +++++++++++++++
 tb/tb_rx_ack_nak_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ack_nak_gen.sv
// Receive-side DLL sequence checker: classifies each checked TLP against NEXT_RCV_SEQ
// and schedules ACK/NAK DLLPs toward the DLLP framer with a valid/ready handshake.
module rx_ack_nak_gen #(
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tlp_valid,
    input  logic [11:0] tlp_seq_num,
    input  logic        tlp_lcrc_ok,
    output logic        tlp_accept,
    output logic        tlp_drop,
    output logic        dllp_valid,
    input  logic        dllp_ready,
    output logic [47:0] dllp_data,
    output logic [11:0] next_rcv_seq
);

    localparam logic [3:0] COALESCE   = 4'(ACK_COALESCE);
    localparam logic [9:0] TIMEOUT_M1 = 10'(ACK_TIMEOUT - 1);
    localparam logic [7:0] TYPE_ACK   = 8'h00;
    localparam logic [7:0] TYPE_NAK   = 8'h10;

    typedef enum logic [1:0] {IDLE, HOLD_ACK, HOLD_NAK} state_t;

    state_t      state;
    logic        nak_sched;
    logic        nak_sent;
    logic        dup_ack;
    logic [3:0]  ack_cnt;
    logic [9:0]  timer;

    logic [11:0] dist_p0;
    logic        in_order_p0;
    logic        dup_p0;
    logic        ahead_p0;
    logic        bad_p0;
    logic        send_nak;
    logic        send_ack;
    logic        launch;
    logic        handshake;
    logic [11:0] ack_seq;

    function automatic logic [3:0] sat_inc_cnt(input logic [3:0] v);
        return (v >= COALESCE) ? COALESCE : v + 4'd1;
    endfunction

    function automatic logic [9:0] sat_inc_timer(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Stage p0: classify the incoming TLP against the current NEXT_RCV_SEQ
    assign dist_p0     = next_rcv_seq - 12'd1 - tlp_seq_num;
    assign bad_p0      = tlp_valid & ~tlp_lcrc_ok;
    assign in_order_p0 = tlp_valid & tlp_lcrc_ok & (tlp_seq_num == next_rcv_seq);
    assign dup_p0      = tlp_valid & tlp_lcrc_ok & ~in_order_p0 & (dist_p0 < 12'd2048);
    assign ahead_p0    = tlp_valid & tlp_lcrc_ok & ~in_order_p0 & ~(dist_p0 < 12'd2048);

    assign send_nak  = (state == IDLE) & nak_sched & ~nak_sent;
    assign send_ack  = (state == IDLE) & ~send_nak &
                       (dup_ack | (ack_cnt >= COALESCE) |
                        ((ack_cnt != 4'd0) & (timer >= TIMEOUT_M1)));
    assign launch    = send_nak | send_ack;
    assign handshake = dllp_valid & dllp_ready;
    assign ack_seq   = next_rcv_seq - 12'd1;

    // Stage p1: sequence and acknowledgement bookkeeping.
    // The launched DLLP covers everything accepted before launch, so the counters restart
    // at launch; TLPs accepted while the DLLP is held are owed a later ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_rcv_seq <= 12'd0;
            nak_sched    <= 1'b0;
            nak_sent     <= 1'b0;
            dup_ack      <= 1'b0;
            ack_cnt      <= 4'd0;
            timer        <= 10'd0;
            tlp_accept   <= 1'b0;
            tlp_drop     <= 1'b0;
        end else begin
            tlp_accept <= in_order_p0;
            tlp_drop   <= bad_p0 | dup_p0 | ahead_p0;

            if (in_order_p0) begin
                next_rcv_seq <= next_rcv_seq + 12'd1;
            end

            if (in_order_p0) begin
                nak_sched <= 1'b0;
                nak_sent  <= 1'b0;
            end else begin
                if (bad_p0 | ahead_p0) begin
                    nak_sched <= 1'b1;
                end
                if (send_nak) begin
                    nak_sent <= 1'b1;
                end
            end

            if (launch) begin
                ack_cnt <= in_order_p0 ? 4'd1 : 4'd0;
            end else if (in_order_p0) begin
                ack_cnt <= sat_inc_cnt(ack_cnt);
            end

            if (dup_p0) begin
                dup_ack <= 1'b1;
            end else if (launch) begin
                dup_ack <= 1'b0;
            end

            if (launch) begin
                timer <= 10'd0;
            end else if ((state == IDLE) && (ack_cnt != 4'd0)) begin
                timer <= sat_inc_timer(timer);
            end
        end
    end

    // Stage p1: DLLP launch FSM; dllp_data is frozen from launch until the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dllp_valid <= 1'b0;
            dllp_data  <= 48'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_nak) begin
                        state      <= HOLD_NAK;
                        dllp_valid <= 1'b1;
                        dllp_data  <= {16'h0000, TYPE_NAK, 12'h000, ack_seq};
                    end else if (send_ack) begin
                        state      <= HOLD_ACK;
                        dllp_valid <= 1'b1;
                        dllp_data  <= {16'h0000, TYPE_ACK, 12'h000, ack_seq};
                    end
                end
                HOLD_ACK, HOLD_NAK: begin
                    if (handshake) begin
                        state      <= IDLE;
                        dllp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dllp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ack_nak_gen.sv
// Scoreboard bench for rx_ack_nak_gen: a behavioural model predicts TLP verdicts and
// DLLP launches (content and cycle); a monitor compares whatever the DUT presents.
module tb_rx_ack_nak_gen;

    localparam int COAL = 4;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tlp_valid = 1'b0;
    logic [11:0] tlp_seq_num = 12'd0;
    logic        tlp_lcrc_ok = 1'b1;
    logic        tlp_accept;
    logic        tlp_drop;
    logic        dllp_valid;
    logic        dllp_ready = 1'b0;
    logic [47:0] dllp_data;
    logic [11:0] next_rcv_seq;

    always #5 clk = ~clk;

    rx_ack_nak_gen #(.ACK_COALESCE(COAL), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .tlp_valid(tlp_valid), .tlp_seq_num(tlp_seq_num),
        .tlp_lcrc_ok(tlp_lcrc_ok), .tlp_accept(tlp_accept), .tlp_drop(tlp_drop),
        .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
        .next_rcv_seq(next_rcv_seq)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clk) begin
        cyc++;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: obligations owed to the link partner
    int  m_next = 0;       // next expected sequence number
    bit  m_nak_owed = 0;   // a NAK is owed since the last in-order TLP
    bit  m_nak_done = 0;   // that NAK has already been launched
    bit  m_dup = 0;        // a duplicate was seen and needs an ACK
    int  m_unacked = 0;    // accepts not yet covered by a launched DLLP (saturating)
    int  m_age = 0;        // idle cycles since unacknowledged accepts began
    bit  m_busy = 0;       // a DLLP is being offered to the framer
    int  shown_next = 0;   // NEXT_RCV_SEQ the DUT should currently show

    typedef struct { logic [47:0] data; int at; } dl_t;
    bit   exp_tlp_q[$];
    dl_t  exp_dl_q[$];
    logic [47:0] got_q[$];
    int   got_cyc_q[$];
    int   last_send_cyc = 0;

    task automatic model_edge(input bit r, input bit tv, input int sq, input bit ok, input bit rdy);
        bit owe_nak, owe_ack, acc, dup, bad;
        int d;
        dl_t e;
        shown_next = m_next;
        if (r) begin
            m_next = 0; m_nak_owed = 0; m_nak_done = 0; m_dup = 0;
            m_unacked = 0; m_age = 0; m_busy = 0;
            exp_dl_q.delete();
            return;
        end
        owe_nak = !m_busy && m_nak_owed && !m_nak_done;
        owe_ack = !m_busy && !owe_nak &&
                  (m_dup || m_unacked >= COAL || (m_unacked > 0 && m_age >= TMO - 1));
        d   = (m_next - 1 - sq + 8192) % 4096;
        acc = tv && ok && (sq == m_next);
        dup = tv && ok && !acc && (d < 2048);
        bad = tv && !acc && !dup;
        if (owe_nak || owe_ack) begin
            e.data = 48'd0;
            e.data[31:24] = owe_nak ? 8'h10 : 8'h00;
            e.data[11:0]  = 12'((m_next + 4095) % 4096);
            e.at = cyc + 1;
            exp_dl_q.push_back(e);
            m_unacked = acc ? 1 : 0;
            m_age = 0;
            m_busy = 1;
        end else begin
            if (m_busy && rdy) m_busy = 0;
            else if (!m_busy && m_unacked > 0 && m_age < 1023) m_age++;
            if (acc && m_unacked < COAL) m_unacked++;
        end
        if (dup) m_dup = 1;
        else if (owe_nak || owe_ack) m_dup = 0;
        if (acc) begin
            m_nak_owed = 0;
            m_nak_done = 0;
            m_next = (m_next + 1) % 4096;
        end else begin
            if (bad) m_nak_owed = 1;
            if (owe_nak) m_nak_done = 1;
        end
        if (tv) exp_tlp_q.push_back(acc);
    endtask

    // Monitor: compares outputs half a cycle after each edge
    bit          prev_valid = 0;
    bit          prev_rdy = 0;
    logic [47:0] prev_data = 48'd0;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            check("reset_outputs", {tlp_accept, tlp_drop, dllp_valid, dllp_data, next_rcv_seq}, 64'd0);
            prev_valid = 0;
        end else begin
            check("next_rcv_seq", next_rcv_seq, shown_next);
            if (tlp_accept || tlp_drop) begin
                if (exp_tlp_q.size() == 0) begin
                    check("tlp_unexpected", {tlp_accept, tlp_drop}, 2'b00);
                end else begin
                    bit a;
                    a = exp_tlp_q.pop_front();
                    check("tlp_verdict", {tlp_accept, tlp_drop}, {a, !a});
                end
            end
            if (dllp_valid) begin
                if (prev_valid && !prev_rdy) begin
                    check("dllp_stable", dllp_data, prev_data);
                end else if (exp_dl_q.size() == 0) begin
                    check("dllp_unexpected", dllp_data, 48'hFFFF_FFFF_FFFF);
                    got_q.push_back(dllp_data);
                    got_cyc_q.push_back(cyc);
                end else begin
                    dl_t e;
                    e = exp_dl_q.pop_front();
                    check("dllp_data", dllp_data, e.data);
                    check("dllp_cycle", cyc, e.at);
                    got_q.push_back(dllp_data);
                    got_cyc_q.push_back(cyc);
                end
            end else if (prev_valid && !prev_rdy) begin
                check("dllp_dropped", 1'b0, 1'b1);
            end
            prev_valid = dllp_valid;
            prev_rdy   = dllp_ready;
            prev_data  = dllp_data;
        end
    end

    task automatic tick(input bit r, input bit tv, input int sq, input bit ok, input bit rdy);
        @(posedge clk);
        #1;
        rst = r;
        tlp_valid = tv;
        tlp_seq_num = 12'(sq);
        tlp_lcrc_ok = ok;
        dllp_ready = rdy;
        if (tv) last_send_cyc = cyc + 1;
        model_edge(r, tv, sq, ok, rdy);
    endtask

    task automatic send(input int sq, input bit ok, input bit rdy);
        tick(0, 1, sq, ok, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 1, rdy);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, 1);
    endtask

    task automatic preload(input int target);
        do_reset();
        for (int i = 0; i < target; i++) send(i, 1, 1);
        idle(80, 1);
    endtask

    int   mark;
    int   naks;
    int   t0;
    logic [47:0] held;

    initial begin
        // Coalesced ACK after four in-order TLPs
        do_reset();
        mark = got_q.size();
        for (int i = 0; i < 4; i++) send(i, 1, 1);
        idle(80, 1);
        check("t1_count", got_q.size() - mark, 1);
        if (got_q.size() > mark) check("t1_ack", got_q[mark], 48'h0000_0000_0003);

        // Timeout ACK for a single TLP
        do_reset();
        mark = got_q.size();
        send(0, 1, 1);
        t0 = last_send_cyc;
        idle(120, 1);
        check("t2_count", got_q.size() - mark, 1);
        if (got_q.size() > mark) begin
            check("t2_ack", got_q[mark], 48'h0);
            check("t2_window", (got_cyc_q[mark] - t0 >= 64) && (got_cyc_q[mark] - t0 <= 66), 1'b1);
        end

        // Bad LCRC: one NAK for two bad TLPs, then recovery
        do_reset();
        for (int i = 0; i < 5; i++) send(i, 1, 1);
        mark = got_q.size();
        send(5, 0, 1);
        send(6, 0, 1);
        idle(10, 1);
        naks = 0;
        for (int i = mark; i < got_q.size(); i++) begin
            held = got_q[i];
            if (held[31:24] == 8'h10) begin
                naks++;
                check("t3_nak", held, 48'h0000_1000_0004);
            end
        end
        check("t3_nak_count", naks, 1);
        send(5, 1, 1);
        idle(2, 1);
        check("t3_next", next_rcv_seq, 12'd6);
        idle(80, 1);

        // Duplicate forces an immediate ACK
        preload(10);
        mark = got_q.size();
        send(7, 1, 1);
        t0 = last_send_cyc;
        idle(5, 1);
        check("t4_count", got_q.size() - mark, 1);
        if (got_q.size() > mark) begin
            check("t4_ack", got_q[mark], 48'h0000_0000_0009);
            check("t4_latency", got_cyc_q[mark] - t0, 1);
        end

        // Ahead of sequence forces a NAK
        preload(10);
        mark = got_q.size();
        send(12, 1, 1);
        idle(5, 1);
        check("t5_count", got_q.size() - mark, 1);
        if (got_q.size() > mark) check("t5_nak", got_q[mark], 48'h0000_1000_0009);

        // Wrap plus backpressure
        preload(4095);
        mark = got_q.size();
        send(4095, 1, 0);
        for (int i = 0; i < 120 && got_q.size() == mark; i++) idle(1, 0);
        check("t6_next_wrap", next_rcv_seq, 12'd0);
        check("t6_launched", got_q.size() - mark, 1);
        held = dllp_data;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) send(0, 1, 0);
            else if (i == 8) send(1, 1, 0);
            else idle(1, 0);
        end
        check("t6_held", dllp_data, held);
        idle(150, 1);
        check("t6_count", got_q.size() - mark, 2);
        if (got_q.size() >= mark + 2) begin
            check("t6_first", got_q[mark], 48'h0000_0000_0FFF);
            check("t6_second", got_q[mark + 1], 48'h0000_0000_0001);
        end

        // Reset while a DLLP is held discards it
        do_reset();
        send(0, 1, 0);
        mark = got_q.size();
        for (int i = 0; i < 120 && got_q.size() == mark; i++) idle(1, 0);
        check("t7_launched", got_q.size() - mark, 1);
        tick(1, 0, 0, 1, 0);
        mark = got_q.size();
        idle(100, 1);
        check("t7_no_resend", got_q.size() - mark, 0);

        // Randomised traffic and backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit rdy;
            r = $urandom_range(0, 9);
            rdy = ($urandom_range(0, 3) != 0);
            case (r)
                0, 1, 2, 3, 4: send(m_next, 1, rdy);
                5: send(int'($urandom_range(0, 4095)), 0, rdy);
                6: send((m_next + 4095 - int'($urandom_range(0, 5))) % 4096, 1, rdy);
                7: send((m_next + int'($urandom_range(1, 3))) % 4096, 1, rdy);
                default: idle(1, rdy);
            endcase
        end
        idle(200, 1);
        check("final_tlp_q_empty", exp_tlp_q.size(), 0);
        check("final_dllp_q_empty", exp_dl_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
